// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one even/odd parity classifier between two requesters.
// Define PARITY_ARB_COUNT_EN to build the saturating even/odd tally counters.
module parity_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             out_valid,
    output logic             out_src,
    output logic             even,
    output logic             odd,
    output logic             busy,
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data_q;
    logic             src_q;
    logic             last_src;
    logic             parity_q;
    logic             req_any;
    logic             winner;
    logic             capture;
    logic             report;
    logic             gnt0_d;
    logic             gnt1_d;
    logic             busy_d;
    logic             unused_data;

    assign req_any = req0 | req1;

    // Only bit 0 decides parity; the rest of the captured word is kept for visibility.
    assign unused_data = ^data_q;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_src;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no branch leaves the signal unassigned
        // and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = EVAL;
            EVAL:    state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture = (state == IDLE) && req_any;
        report  = (state == REPORT);
        gnt0_d  = capture && !winner;
        gnt1_d  = capture && winner;
        busy_d  = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: data_q has no reset; it is only read after a capture has loaded it.
        if (capture) begin
            data_q <= winner ? data1 : data0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q    <= 1'b0;
            last_src <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            if (capture) begin
                src_q    <= winner;
                last_src <= winner;
            end
            if (state == EVAL) begin
                parity_q <= data_q[0];
            end
        end
    end

    // Registered outputs; even/odd/out_src hold until the next report.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            out_valid <= 1'b0;
            out_src   <= 1'b0;
            even      <= 1'b0;
            odd       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            out_valid <= report;
            busy      <= busy_d;
            if (report) begin
                out_src <= src_q;
                even    <= ~parity_q;
                odd     <= parity_q;
            end
        end
    end

`ifdef PARITY_ARB_COUNT_EN
    logic [CNT_W-1:0] even_cnt_q;
    logic [CNT_W-1:0] odd_cnt_q;

    // Tallies stop at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            even_cnt_q <= '0;
            odd_cnt_q  <= '0;
        end else if (report) begin
            if (parity_q) begin
                if (odd_cnt_q != '1) odd_cnt_q <= odd_cnt_q + CNT_W'(1);
            end else begin
                if (even_cnt_q != '1) even_cnt_q <= even_cnt_q + CNT_W'(1);
            end
        end
    end

    assign even_cnt = even_cnt_q;
    assign odd_cnt  = odd_cnt_q;
`else
    assign even_cnt = '0;
    assign odd_cnt  = '0;
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// Scoreboard bench for parity_arbiter; counter expectations follow PARITY_ARB_COUNT_EN.
module tb_parity_arbiter;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PARITY_ARB_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic             src;
        logic             odd;
        logic [CNT_W-1:0] even_cnt;
        logic [CNT_W-1:0] odd_cnt;
    } result_t;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             req0  = 1'b0;
    logic             req1  = 1'b0;
    logic [WIDTH-1:0] data0 = '0;
    logic [WIDTH-1:0] data1 = '0;
    logic             gnt0, gnt1, out_valid, out_src, even, odd, busy;
    logic [CNT_W-1:0] even_cnt, odd_cnt;

    result_t res_q[$];
    logic    grant_q[$];
    int      tests_run    = 0;
    int      tests_failed = 0;
    int      cyc          = 0;
    int      gnt_cyc      = -100;
    int      model_even   = 0;
    int      model_odd    = 0;

    // Values the held outputs must show between reports.
    logic             held_src  = 1'b0;
    logic             held_even = 1'b0;
    logic             held_odd  = 1'b0;
    logic [CNT_W-1:0] held_ecnt = '0;
    logic [CNT_W-1:0] held_ocnt = '0;

    parity_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .out_valid (out_valid),
        .out_src   (out_src),
        .even      (even),
        .odd       (odd),
        .busy      (busy),
        .even_cnt  (even_cnt),
        .odd_cnt   (odd_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: grants and results popped from the scoreboard, timing checked against the last grant.
    always @(negedge clk) begin : monitor
        logic    g;
        logic    exp_valid;
        logic    exp_busy;
        result_t r;
        cyc = cyc + 1;
        if (!reset) begin
            if (gnt0 || gnt1) begin
                tests_run++;
                if (grant_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_grant cyc=%0d gnt1,gnt0=%b%b", cyc, gnt1, gnt0);
                end else begin
                    g = grant_q.pop_front();
                    if ({gnt1, gnt0} !== (g ? 2'b10 : 2'b01)) begin
                        tests_failed++;
                        $display("FAIL grant_winner cyc=%0d got gnt1,gnt0=%b%b expected src=%0d",
                                 cyc, gnt1, gnt0, g);
                    end
                end
                tests_run++;
                if (cyc - gnt_cyc < 3) begin
                    tests_failed++;
                    $display("FAIL grant_spacing cyc=%0d got %0d cycles expected >=3", cyc, cyc - gnt_cyc);
                end
                gnt_cyc = cyc;
            end
            exp_valid = (cyc == gnt_cyc + 2);
            exp_busy  = (cyc - gnt_cyc <= 1);
            tests_run++;
            if (out_valid !== exp_valid) begin
                tests_failed++;
                $display("FAIL out_valid_timing cyc=%0d got %b expected %b", cyc, out_valid, exp_valid);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, exp_busy);
            end
            if (out_valid) begin
                tests_run++;
                if (res_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_result cyc=%0d", cyc);
                end else begin
                    r         = res_q.pop_front();
                    held_src  = r.src;
                    held_odd  = r.odd;
                    held_even = ~r.odd;
                    held_ecnt = r.even_cnt;
                    held_ocnt = r.odd_cnt;
                end
            end
            tests_run++;
            if ({out_src, even, odd, even_cnt, odd_cnt} !==
                {held_src, held_even, held_odd, held_ecnt, held_ocnt}) begin
                tests_failed++;
                $display("FAIL result cyc=%0d got src=%b even=%b odd=%b ecnt=%0d ocnt=%0d expected src=%b even=%b odd=%b ecnt=%0d ocnt=%0d",
                         cyc, out_src, even, odd, even_cnt, odd_cnt,
                         held_src, held_even, held_odd, held_ecnt, held_ocnt);
            end
        end
    end

    task automatic push_result(input logic src, input logic [WIDTH-1:0] d);
        result_t r;
        if (d[0]) model_odd  = (model_odd  == CNT_MAX) ? model_odd  : model_odd + 1;
        else      model_even = (model_even == CNT_MAX) ? model_even : model_even + 1;
        r.src      = src;
        r.odd      = d[0];
        r.even_cnt = CNT_ON ? CNT_W'(model_even) : '0;
        r.odd_cnt  = CNT_ON ? CNT_W'(model_odd)  : '0;
        res_q.push_back(r);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        @(posedge clk); #1;
        res_q.delete();
        grant_q.delete();
        model_even = 0;
        model_odd  = 0;
        gnt_cyc    = -100;
        held_src   = 1'b0;
        held_even  = 1'b0;
        held_odd   = 1'b0;
        held_ecnt  = '0;
        held_ocnt  = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Single-requester transaction: raise req, wait for its grant, drop req on the next edge.
    task automatic request(input logic src, input logic [WIDTH-1:0] d);
        int   n;
        logic seen;
        grant_q.push_back(src);
        push_result(src, d);
        if (src) begin data1 = d; req1 = 1'b1; end
        else     begin data0 = d; req0 = 1'b1; end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = src ? gnt1 : gnt0;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL grant_timeout src=%0d got no grant in %0d cycles expected one", src, n);
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((res_q.size() != 0 || grant_q.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (res_q.size() != 0 || grant_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_%s got %0d results %0d grants pending expected 0",
                     name, res_q.size(), grant_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if ({gnt0, gnt1, out_valid, out_src, even, odd, busy, even_cnt, odd_cnt} !== '0) begin
                tests_failed++;
                $display("FAIL reset_idle cycle=%0d got gnt=%b%b v=%b src=%b e=%b o=%b busy=%b cnt=%0d/%0d expected all 0",
                         i, gnt1, gnt0, out_valid, out_src, even, odd, busy, even_cnt, odd_cnt);
            end
        end
        @(posedge clk); #1;
        request(1'b0, 8'h04);
        drain("reset");
        tests_run++;
        if ({even, odd, out_src, even_cnt} !== {1'b1, 1'b0, 1'b0, CNT_ON ? CNT_W'(1) : CNT_W'(0)}) begin
            tests_failed++;
            $display("FAIL first_word got even=%b odd=%b src=%b ecnt=%0d expected even=1 odd=0 src=0 ecnt=%0d",
                     even, odd, out_src, even_cnt, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_tie();
        do_reset();
        @(posedge clk); #1;
        grant_q.push_back(1'b0); push_result(1'b0, 8'h03);
        grant_q.push_back(1'b1); push_result(1'b1, 8'h10);
        grant_q.push_back(1'b0); push_result(1'b0, 8'h03);
        grant_q.push_back(1'b1); push_result(1'b1, 8'h10);
        data0 = 8'h03;
        data1 = 8'h10;
        req0  = 1'b1;
        req1  = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        drain("tie");
    endtask

    task automatic test_reset_mid();
        int   n;
        logic seen;
        do_reset();
        @(posedge clk); #1;
        grant_q.push_back(1'b0);
        data0 = 8'h01;
        req0  = 1'b1;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = gnt0;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL mid_grant_timeout got no gnt0 expected one");
        end
        // Now in the EVAL cycle: reset takes effect on the coming edge.
        reset = 1'b1;
        req0  = 1'b0;
        do_reset();
        @(negedge clk);
        tests_run++;
        if ({out_valid, busy, odd_cnt, odd} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset got v=%b busy=%b ocnt=%0d odd=%b expected all 0",
                     out_valid, busy, odd_cnt, odd);
        end
        repeat (5) @(posedge clk);
        #1;
        grant_q.push_back(1'b0);
        push_result(1'b0, 8'h02);
        data0 = 8'h02;
        data1 = 8'h05;
        req0  = 1'b1;
        req1  = 1'b1;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = gnt0 | gnt1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL post_reset_tie_timeout got no grant expected gnt0");
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        drain("reset_mid");
    endtask

    task automatic test_saturate();
        logic [WIDTH-1:0] d;
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            d = WIDTH'(2 * i + 1);
            request(1'b0, d);
        end
        drain("saturate");
        tests_run++;
        if ({odd_cnt, even_cnt} !== {CNT_ON ? CNT_W'(CNT_MAX) : CNT_W'(0), CNT_W'(0)}) begin
            tests_failed++;
            $display("FAIL saturate got ocnt=%0d ecnt=%0d expected ocnt=%0d ecnt=0",
                     odd_cnt, even_cnt, CNT_ON ? CNT_MAX : 0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(posedge clk); #1;
        request(1'b1, 8'hFF);
        request(1'b0, 8'h00);
        request(1'b0, 8'h81);
        request(1'b1, 8'h42);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_tie();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
